param_victim_buffer: RTL and testbench

PARAM_VICTIM_BUFFER -- requirements
Module: param_victim_buffer

---
 rtl/param_victim_buffer.sv | 170 +++++++++++++++++
 tb/tb_param_victim_buffer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_victim_buffer.sv
// Victim buffer between a cache and the next memory level.
// Evicted lines park in a small circular FIFO and drain to memory in the
// background. Cache reads that hit a parked line are served from the buffer.
module param_victim_buffer #(
  parameter int DEPTH    = 8,
  parameter int LINE_W   = 128,
  parameter int ADDR_W   = 16,
  parameter int OFFSET_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     buf_mem_read,
  input  logic                     buf_mem_write,
  input  logic [ADDR_W-1:0]        buf_mem_address,
  input  logic [LINE_W-1:0]        buf_mem_wdata,
  output logic                     buf_mem_resp,
  output logic [LINE_W-1:0]        buf_mem_rdata,
  input  logic                     flush,
  output logic                     flush_done,
  input  logic                     super_mem_resp,
  input  logic [LINE_W-1:0]        super_mem_rdata,
  output logic                     super_mem_read,
  output logic                     super_mem_write,
  output logic [ADDR_W-1:0]        super_mem_address,
  output logic [LINE_W-1:0]        super_mem_wdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int TAG_W = ADDR_W - OFFSET_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, RD_MISS, DRAIN, ACK} state_t;

  state_t            state, state_next;
  logic [DEPTH-1:0]  valid;
  logic [TAG_W-1:0]  tags  [DEPTH];
  logic [LINE_W-1:0] lines [DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [TAG_W-1:0]  req_tag;
  logic              hit;
  logic [PTR_W-1:0]  hit_idx;
  logic              do_overwrite, do_push, do_read_hit, do_miss_fill, do_pop;

  assign req_tag = buf_mem_address[ADDR_W-1:OFFSET_W];
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);

  // Tag match across all valid entries; at most one entry can hold a given tag.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (tags[i] == req_tag)) begin
        hit     = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end
  end

  // Next-state and per-cycle action decode; cache requests win over draining in IDLE.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_next   = state;
    do_overwrite = 1'b0;
    do_push      = 1'b0;
    do_read_hit  = 1'b0;
    do_miss_fill = 1'b0;
    do_pop       = 1'b0;
    case (state)
      IDLE: begin
        if (buf_mem_write) begin
          if (hit) begin
            do_overwrite = 1'b1;
            state_next   = ACK;
          end else if (!full) begin
            do_push    = 1'b1;
            state_next = ACK;
          end else begin
            state_next = DRAIN;  // make room; the write is retried on return to IDLE
          end
        end else if (buf_mem_read) begin
          if (hit) begin
            do_read_hit = 1'b1;
            state_next  = ACK;
          end else begin
            state_next = RD_MISS;
          end
        end else if (!empty) begin
          state_next = DRAIN;
        end
      end
      RD_MISS: begin
        if (super_mem_resp) begin
          do_miss_fill = 1'b1;
          state_next   = ACK;
        end
      end
      DRAIN: begin
        if (super_mem_resp) begin
          do_pop     = 1'b1;
          state_next = IDLE;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the state register so reset clears them immediately.
  always_comb begin
    buf_mem_resp      = (state == ACK);
    super_mem_read    = (state == RD_MISS);
    super_mem_write   = (state == DRAIN);
    flush_done        = flush && empty && (state == IDLE);
    super_mem_address = '0;
    super_mem_wdata   = '0;
    if (state == RD_MISS) begin
      super_mem_address = buf_mem_address;
    end else if (state == DRAIN) begin
      super_mem_address = {tags[head], {OFFSET_W{1'b0}}};
      super_mem_wdata   = lines[head];
    end
  end

  // Control state: FSM, pointers, occupancy, valid bits and the read-data register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      valid         <= '0;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      buf_mem_rdata <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state <= state_next;
      if (do_push) begin
        valid[tail] <= 1'b1;
        tail        <= tail + 1'b1;
        count       <= count + 1'b1;
      end
      if (do_pop) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
        count       <= count - 1'b1;
      end
      if (do_read_hit) begin
        buf_mem_rdata <= lines[hit_idx];
      end else if (do_miss_fill) begin
        buf_mem_rdata <= super_mem_rdata;
      end
    end
  end

  // Tag and line storage; entry contents only matter while the valid bit is set.
  always_ff @(posedge clk) begin
    // NOTE: the storage arrays are deliberately not reset; the reset valid bits make stale contents unreachable.
    if (do_push) begin
      tags[tail]  <= req_tag;
      lines[tail] <= buf_mem_wdata;
    end
    if (do_overwrite) begin
      lines[hit_idx] <= buf_mem_wdata;
    end
  end

endmodule

// File: tb/tb_param_victim_buffer.sv
// Self-checking bench for param_victim_buffer (DEPTH=4, LINE_W=128, OFFSET_W=4).
// A behavioural memory answers requests after a programmable delay or stalls.
module tb_param_victim_buffer;

  localparam int DEPTH = 4;
  localparam int LW    = 128;
  localparam int AW    = 16;

  localparam logic [LW-1:0] LA  = {4{32'hA1A1_0001}};
  localparam logic [LW-1:0] LA2 = {4{32'hA2A2_0002}};
  localparam logic [LW-1:0] LB  = {4{32'hB0B0_0003}};
  localparam logic [LW-1:0] LC  = {4{32'hC0C0_0004}};
  localparam logic [LW-1:0] LD  = {4{32'hD0D0_0005}};
  localparam logic [LW-1:0] L1  = {4{32'h1111_1111}};
  localparam logic [LW-1:0] L2  = {4{32'h2222_2222}};
  localparam logic [LW-1:0] L3  = {4{32'h3333_3333}};
  localparam logic [LW-1:0] L4  = {4{32'h4444_4444}};
  localparam logic [LW-1:0] L5  = {4{32'h5555_5555}};

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          buf_mem_read = 1'b0, buf_mem_write = 1'b0;
  logic [AW-1:0] buf_mem_address = '0;
  logic [LW-1:0] buf_mem_wdata = '0;
  logic          buf_mem_resp;
  logic [LW-1:0] buf_mem_rdata;
  logic          flush = 1'b0, flush_done;
  logic          super_mem_resp = 1'b0;
  logic [LW-1:0] super_mem_rdata = '0;
  logic          super_mem_read, super_mem_write;
  logic [AW-1:0] super_mem_address;
  logic [LW-1:0] super_mem_wdata;
  logic [2:0]    count;
  logic          full, empty;

  param_victim_buffer #(.DEPTH(DEPTH), .LINE_W(LW), .ADDR_W(AW), .OFFSET_W(4)) dut (
    .clk(clk), .reset(reset),
    .buf_mem_read(buf_mem_read), .buf_mem_write(buf_mem_write),
    .buf_mem_address(buf_mem_address), .buf_mem_wdata(buf_mem_wdata),
    .buf_mem_resp(buf_mem_resp), .buf_mem_rdata(buf_mem_rdata),
    .flush(flush), .flush_done(flush_done),
    .super_mem_resp(super_mem_resp), .super_mem_rdata(super_mem_rdata),
    .super_mem_read(super_mem_read), .super_mem_write(super_mem_write),
    .super_mem_address(super_mem_address), .super_mem_wdata(super_mem_wdata),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Memory model state
  logic          mem_stall = 1'b1;
  int            mem_delay = 1;
  logic          force_resp = 1'b0;
  logic [LW-1:0] mem_rdata_val = '0;
  int            wait_cnt = 0;
  int            rd_cycles = 0;
  int            both_cnt = 0;
  logic [AW-1:0] rd_addr_seen = '0;
  logic [AW-1:0] drain_addr[$];
  logic [LW-1:0] drain_data[$];

  // Memory responder: drives resp on the falling edge, logs every completed drain.
  always @(negedge clk) begin
    logic fire;
    fire = 1'b0;
    if (super_mem_read && super_mem_write) both_cnt++;
    if (super_mem_read) begin
      rd_cycles++;
      rd_addr_seen = super_mem_address;
    end
    if ((super_mem_read || super_mem_write) && !mem_stall && !reset) begin
      wait_cnt++;
      if (wait_cnt >= mem_delay) begin
        fire = 1'b1;
        wait_cnt = 0;
        if (super_mem_write) begin
          drain_addr.push_back(super_mem_address);
          drain_data.push_back(super_mem_wdata);
        end
      end
    end else begin
      wait_cnt = 0;
    end
    super_mem_resp  = fire || force_resp;
    super_mem_rdata = fire ? mem_rdata_val : '0;
  end

  function automatic logic [LW-1:0] q_addr(input int i);
    return (i < drain_addr.size()) ? LW'(drain_addr[i]) : 'x;
  endfunction

  function automatic logic [LW-1:0] q_data(input int i);
    return (i < drain_data.size()) ? drain_data[i] : 'x;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    buf_mem_read = 1'b0;
    buf_mem_write = 1'b0;
    flush = 1'b0;
    force_resp = 1'b0;
    mem_stall = 1'b1;
    mem_delay = 1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    drain_addr.delete();
    drain_data.delete();
    rd_cycles = 0;
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [AW-1:0] addr, input logic [LW-1:0] wd);
    buf_mem_write = wr;
    buf_mem_read = rd;
    buf_mem_address = addr;
    buf_mem_wdata = wd;
  endtask

  // Waits (bounded) for buf_mem_resp, then drops the request after the ACK cycle.
  task automatic wait_resp(input string name, output logic [LW-1:0] rd, output int n);
    logic got;
    got = 1'b0;
    rd = '0;
    n = 0;
    while (n < 60 && !got) begin
      @(negedge clk);
      n++;
      if (buf_mem_resp) begin
        got = 1'b1;
        rd = buf_mem_rdata;
      end
    end
    check(name, LW'(got), LW'(1));
    @(posedge clk);
    #1;
    buf_mem_read = 1'b0;
    buf_mem_write = 1'b0;
  endtask

  task automatic op(input string name, input logic wr, input logic rd, input logic [AW-1:0] addr, input logic [LW-1:0] wd);
    logic [LW-1:0] r;
    int n;
    drive(wr, rd, addr, wd);
    wait_resp(name, r, n);
  endtask

  task automatic wait_empty(input string name);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (count == 0 && !super_mem_write) got = 1'b1;
    end
    check(name, LW'(got), LW'(1));
  endtask

  typedef struct {
    logic          wr;
    logic          rd;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic          chk_rd;
    logic [LW-1:0] exp_rd;
    logic [2:0]    exp_cnt;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [LW-1:0] r;
    int n;

    // Hit/write traffic with memory stalled: every read must be a buffer hit.
    vecs[0] = '{wr: 1, rd: 0, addr: 16'h1230, wdata: LA,  chk_rd: 0, exp_rd: '0, exp_cnt: 1};
    vecs[1] = '{wr: 0, rd: 1, addr: 16'h1238, wdata: '0,  chk_rd: 1, exp_rd: LA, exp_cnt: 1};
    vecs[2] = '{wr: 1, rd: 0, addr: 16'h2000, wdata: LB,  chk_rd: 0, exp_rd: '0, exp_cnt: 2};
    vecs[3] = '{wr: 1, rd: 0, addr: 16'h123F, wdata: LA2, chk_rd: 0, exp_rd: '0, exp_cnt: 2};
    vecs[4] = '{wr: 0, rd: 1, addr: 16'h1230, wdata: '0,  chk_rd: 1, exp_rd: LA2, exp_cnt: 2};
    vecs[5] = '{wr: 0, rd: 1, addr: 16'h2004, wdata: '0,  chk_rd: 1, exp_rd: LB, exp_cnt: 2};
    vecs[6] = '{wr: 1, rd: 1, addr: 16'h3000, wdata: LD,  chk_rd: 1, exp_rd: LB, exp_cnt: 3};
    vecs[7] = '{wr: 0, rd: 1, addr: 16'h3000, wdata: '0,  chk_rd: 1, exp_rd: LD, exp_cnt: 3};

    // Reset values while reset is held
    #1;
    check("rst_resp", LW'(buf_mem_resp), 0);
    check("rst_count", LW'(count), 0);
    check("rst_empty", LW'(empty), 1);
    check("rst_full", LW'(full), 0);
    check("rst_smw", LW'(super_mem_write), 0);
    check("rst_smr", LW'(super_mem_read), 0);
    check("rst_rdata", buf_mem_rdata, 0);

    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata);
      wait_resp($sformatf("vec%0d_resp", i), r, n);
      check($sformatf("vec%0d_lat", i), LW'(n), 2);
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), r, vecs[i].exp_rd);
      check($sformatf("vec%0d_count", i), LW'(count), LW'(vecs[i].exp_cnt));
    end
    check("vec_no_smr", LW'(rd_cycles), 0);
    // Idle with entries buffered: background drain of the oldest line starts.
    repeat (2) @(negedge clk);
    check("bg_drain_w", LW'(super_mem_write), 1);
    check("bg_drain_addr", LW'(super_mem_address), LW'(16'h1230));
    check("bg_drain_data", super_mem_wdata, LA2);
    check("bg_drain_r", LW'(super_mem_read), 0);

    // Full buffer: the fifth write forces a drain of the oldest line first.
    do_reset();
    op("full_w1", 1, 0, 16'h1000, L1);
    op("full_w2", 1, 0, 16'h2000, L2);
    op("full_w3", 1, 0, 16'h3000, L3);
    op("full_w4", 1, 0, 16'h4000, L4);
    check("full_flag", LW'(full), 1);
    check("full_count", LW'(count), 4);
    drive(1, 0, 16'h5000, L5);
    repeat (2) @(negedge clk);
    check("full_drain_w", LW'(super_mem_write), 1);
    check("full_drain_addr", LW'(super_mem_address), LW'(16'h1000));
    check("full_drain_data", super_mem_wdata, L1);
    check("full_no_resp", LW'(buf_mem_resp), 0);
    #1 mem_stall = 1'b0;
    wait_resp("full_w5", r, n);
    check("full_after_count", LW'(count), 4);
    check("full_after_flag", LW'(full), 1);
    check("full_q_size", LW'(drain_addr.size()), 1);
    check("full_q_addr", q_addr(0), LW'(16'h1000));

    // Rewrite of a buffered line before it drains: drain carries the new data.
    do_reset();
    op("ow_w1", 1, 0, 16'h1000, LA);
    op("ow_w2", 1, 0, 16'h1008, LB);
    check("ow_count", LW'(count), 1);
    mem_stall = 1'b0;
    wait_empty("ow_empty");
    check("ow_q_size", LW'(drain_addr.size()), 1);
    check("ow_q_addr", q_addr(0), LW'(16'h1000));
    check("ow_q_data", q_data(0), LB);

    // Read miss with a 5-cycle memory latency.
    do_reset();
    mem_stall = 1'b0;
    mem_delay = 5;
    mem_rdata_val = LC;
    drive(0, 1, 16'h7004, '0);
    wait_resp("miss_resp", r, n);
    check("miss_rdata", r, LC);
    check("miss_rd_cycles", LW'(rd_cycles), 5);
    check("miss_rd_addr", LW'(rd_addr_seen), LW'(16'h7004));
    check("miss_count", LW'(count), 0);
    check("miss_no_drain", LW'(drain_addr.size()), 0);

    // Flush drains three entries in FIFO order, then flush_done rises.
    do_reset();
    op("fl_w1", 1, 0, 16'h1000, L1);
    op("fl_w2", 1, 0, 16'h2000, L2);
    op("fl_w3", 1, 0, 16'h3000, L3);
    flush = 1'b1;
    @(negedge clk);
    check("fl_not_done", LW'(flush_done), 0);
    mem_stall = 1'b0;
    begin
      logic got;
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
        @(negedge clk);
        if (flush_done) got = 1'b1;
      end
      check("fl_done", LW'(got), 1);
    end
    check("fl_count", LW'(count), 0);
    check("fl_q_size", LW'(drain_addr.size()), 3);
    check("fl_q0", q_addr(0), LW'(16'h1000));
    check("fl_q1", q_addr(1), LW'(16'h2000));
    check("fl_q2", q_addr(2), LW'(16'h3000));
    check("fl_d2", q_data(2), L3);
    flush = 1'b0;
    @(negedge clk);
    check("fl_done_low", LW'(flush_done), 0);

    // Reset in the middle of a drain; the late memory response is ignored.
    do_reset();
    op("rd_w1", 1, 0, 16'h1000, L1);
    op("rd_w2", 1, 0, 16'h2000, L2);
    drive(0, 1, 16'h1000, '0);
    wait_resp("rd_hit", r, n);
    check("rd_hit_data", r, L1);
    repeat (2) @(negedge clk);
    check("rd_in_drain", LW'(super_mem_write), 1);
    #2 reset = 1'b1;
    #1;
    check("rd_rst_smw", LW'(super_mem_write), 0);
    check("rd_rst_count", LW'(count), 0);
    check("rd_rst_empty", LW'(empty), 1);
    check("rd_rst_rdata", buf_mem_rdata, 0);
    check("rd_rst_addr", LW'(super_mem_address), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    force_resp = 1'b1;
    @(posedge clk);
    #1 force_resp = 1'b0;
    @(negedge clk);
    check("rd_late_count", LW'(count), 0);
    check("rd_late_smw", LW'(super_mem_write), 0);
    check("rd_late_resp", LW'(buf_mem_resp), 0);

    check("never_both", LW'(both_cnt), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
